// File: rtl/mems_dac_sequencer_pkg.sv
// Shared types, DAC command codes, init words and frame builder for the MEMS DAC sequencer.
package mems_pkg;

  typedef enum logic [2:0] {
    ST_INIT_SEND,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_ARMED,
    ST_X_SEND,
    ST_X_WAIT,
    ST_Y_SEND,
    ST_Y_WAIT
  } state_e;

  localparam logic [2:0]  CMD_WRITE_N       = 3'b000;
  localparam logic [2:0]  CMD_WRITE_UPD_ALL = 3'b010;

  localparam logic [23:0] INIT_RESET  = 24'h280001;
  localparam logic [23:0] INIT_REF_ON = 24'h380001;
  localparam int          INIT_LEN    = 2;

  localparam logic [15:0] PARK_CODE = 16'h8000;

  function automatic logic [23:0] make_frame(input logic [2:0]  cmd,
                                             input logic [2:0]  addr,
                                             input logic [15:0] data);
    return {2'b00, cmd, addr, data};
  endfunction

  function automatic logic [23:0] init_word(input logic idx);
    return idx ? INIT_REF_ON : INIT_RESET;
  endfunction

endpackage

// File: rtl/mems_dac_sequencer_if.sv
// Upstream sample stream plus SPI master start/data handshake between the sequencer and its neighbours.
interface mems_dac_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_x;
  logic [15:0] s_y;
  logic        spi_start;
  logic [23:0] spi_data;
  logic        spi_busy;
  logic        spi_done;

  modport master (
    output s_ready, spi_start, spi_data,
    input  s_valid, s_x, s_y, spi_busy, spi_done
  );

  modport slave (
    input  s_ready, spi_start, spi_data,
    output s_valid, s_x, s_y, spi_busy, spi_done
  );
endinterface

// File: rtl/mems_dac_sequencer_tick_gen.sv
// Sample-rate divider: counts 0..TICK_DIV-1 while enabled, tick on the last count; clr restarts the period.
module mems_tick_gen #(
  parameter int TICK_DIV = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);
endmodule

// File: rtl/mems_dac_sequencer.sv
// Drives a dual-channel DAC through the SPI master: init words after reset, then one X/Y pair per sample tick.
// Optional macro MEMS_PARK_EN: send mid-scale park frames to both axes when streaming stops.
//
// state      | meaning
// INIT_SEND  | waiting for SPI idle to launch init word init_idx
// INIT_WAIT  | init word in flight
// IDLE       | init complete, waiting for enable
// ARMED      | streaming, waiting for the next sample tick
// X_SEND     | X frame ready, waiting for SPI idle
// X_WAIT     | X frame in flight
// Y_SEND     | Y (update-all) frame ready, waiting for SPI idle
// Y_WAIT     | Y frame in flight; decides ARMED / IDLE / park
module mems_dac_sequencer
  import mems_pkg::*;
#(
  parameter int         TICK_DIV = 2500,
  parameter logic [2:0] X_ADDR   = 3'b000,
  parameter logic [2:0] Y_ADDR   = 3'b001,
  parameter int         CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mems_dac_sequencer_if.master bus,
  input  logic                 enable,
  input  logic                 clear_status,
  output logic                 init_done,
  output logic                 running,
  output logic [CNT_W-1:0]     underrun_cnt,
  output logic                 overrun
);

  state_e             state_q, state_d;
  logic               init_idx_q, init_idx_d;
  logic [15:0]        x_q, x_d, y_q, y_d;
  logic               spi_start_q, spi_start_d;
  logic [23:0]        spi_data_q, spi_data_d;
  logic               init_done_q, init_done_d;
  logic               running_q, running_d;
  logic [CNT_W-1:0]   underrun_q, underrun_d;
  logic               overrun_q, overrun_d;
  logic               tick, tick_clr, s_ready_c, underrun_inc;
`ifdef MEMS_PARK_EN
  logic               park_q, park_d;
`endif

  mems_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (running_q),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    x_d          = x_q;
    y_d          = y_q;
    spi_start_d  = 1'b0;
    spi_data_d   = spi_data_q;
    init_done_d  = init_done_q;
    running_d    = running_q;
    tick_clr     = 1'b0;
    s_ready_c    = 1'b0;
    underrun_inc = 1'b0;
`ifdef MEMS_PARK_EN
    park_d       = park_q;
`endif
    case (state_q)
      ST_INIT_SEND: if (!bus.spi_busy) begin
        spi_start_d = 1'b1;
        spi_data_d  = init_word(init_idx_q);
        state_d     = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: if (bus.spi_done) begin
        if (init_idx_q == 1'(INIT_LEN - 1)) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
          state_d    = ST_INIT_SEND;
        end
      end
      ST_IDLE: if (enable) begin
        running_d = 1'b1;
        tick_clr  = 1'b1;
        state_d   = ST_ARMED;
      end
      ST_ARMED: begin
        s_ready_c = tick;
        // An accepted sample always completes as a pair, even if enable just fell.
        if (tick && bus.s_valid) begin
          x_d        = bus.s_x;
          y_d        = bus.s_y;
          spi_data_d = make_frame(CMD_WRITE_N, X_ADDR, bus.s_x);
          if (!bus.spi_busy) begin
            spi_start_d = 1'b1;
            state_d     = ST_X_WAIT;
          end else begin
            state_d = ST_X_SEND;
          end
        end else if (!enable) begin
`ifdef MEMS_PARK_EN
          x_d     = PARK_CODE;
          y_d     = PARK_CODE;
          park_d  = 1'b1;
          state_d = ST_X_SEND;
`else
          running_d = 1'b0;
          state_d   = ST_IDLE;
`endif
        end else if (tick) begin
          underrun_inc = 1'b1;
        end
      end
      ST_X_SEND: if (!bus.spi_busy) begin
        spi_start_d = 1'b1;
        spi_data_d  = make_frame(CMD_WRITE_N, X_ADDR, x_q);
        state_d     = ST_X_WAIT;
      end
      ST_X_WAIT: if (bus.spi_done) state_d = ST_Y_SEND;
      ST_Y_SEND: if (!bus.spi_busy) begin
        spi_start_d = 1'b1;
        spi_data_d  = make_frame(CMD_WRITE_UPD_ALL, Y_ADDR, y_q);
        state_d     = ST_Y_WAIT;
      end
      ST_Y_WAIT: if (bus.spi_done) begin
`ifdef MEMS_PARK_EN
        if (park_q) begin
          park_d    = 1'b0;
          running_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (!enable) begin
          x_d     = PARK_CODE;
          y_d     = PARK_CODE;
          park_d  = 1'b1;
          state_d = ST_X_SEND;
        end else begin
          state_d = ST_ARMED;
        end
`else
        if (!enable) begin
          running_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_ARMED;
        end
`endif
      end
      default: state_d = ST_INIT_SEND;
    endcase

    // Status: clear wins over any same-cycle increment or set.
    underrun_d = underrun_q;
    overrun_d  = overrun_q;
    if (clear_status) begin
      underrun_d = '0;
      overrun_d  = 1'b0;
    end else begin
      if (underrun_inc && (underrun_q != '1)) underrun_d = underrun_q + CNT_W'(1);
      if (tick && (state_q != ST_ARMED))      overrun_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT_SEND;
      init_idx_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      spi_start_q <= 1'b0;
      spi_data_q  <= '0;
      init_done_q <= 1'b0;
      running_q   <= 1'b0;
      underrun_q  <= '0;
      overrun_q   <= 1'b0;
`ifdef MEMS_PARK_EN
      park_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
      init_done_q <= init_done_d;
      running_q   <= running_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
`ifdef MEMS_PARK_EN
      park_q      <= park_d;
`endif
    end
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.spi_start = spi_start_q;
  assign bus.spi_data  = spi_data_q;
  assign init_done     = init_done_q;
  assign running       = running_q;
  assign underrun_cnt  = underrun_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_mems_dac_sequencer.sv
// Self-checking bench for mems_dac_sequencer: behavioural SPI master plus a frame-sequence reference model.
module tb_mems_dac_sequencer;

  localparam int TD  = 256;
  localparam int X_A = 0;
  localparam int Y_A = 1;

  logic        clk, rst, enable, clear_status;
  logic        init_done, running, overrun;
  logic [15:0] underrun_cnt;

  mems_dac_sequencer_if bus ();

  mems_dac_sequencer #(
    .TICK_DIV (TD),
    .X_ADDR   (3'(X_A)),
    .Y_ADDR   (3'(Y_A)),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .enable       (enable),
    .clear_status (clear_status),
    .init_done    (init_done),
    .running      (running),
    .underrun_cnt (underrun_cnt),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [23:0] frames[$];
  logic [23:0] exp_q[$];
  int          starts[$];
  int          accs[$];
  int          busy_len, hold_extra, remain;
  int          stab_err = 0;
  int          dbl_start = 0;
  bit          active = 0;
  logic [23:0] cur;

  // SPI master model: busy for busy_len (+hold_extra once) cycles after a start, then a one-cycle done.
  always @(negedge clk) begin
    if (rst) begin
      active       = 0;
      bus.spi_busy = 1'b0;
      bus.spi_done = 1'b0;
    end else begin
      bus.spi_done = 1'b0;
      if (bus.s_valid && bus.s_ready) accs.push_back(cyc);
      if (active) begin
        if (bus.spi_data !== cur) stab_err++;
        if (bus.spi_start) dbl_start++;
        remain--;
        if (remain == 0) begin
          active       = 0;
          bus.spi_busy = 1'b0;
          bus.spi_done = 1'b1;
        end
      end else if (bus.spi_start) begin
        cur = bus.spi_data;
        frames.push_back(cur);
        starts.push_back(cyc);
        active       = 1;
        bus.spi_busy = 1'b1;
        remain       = busy_len + hold_extra;
        hold_extra   = 0;
      end
    end
  end

  function automatic logic [23:0] xf(input logic [15:0] v);
    return 24'(X_A * 65536 + int'(v));
  endfunction

  function automatic logic [23:0] yf(input logic [15:0] v);
    return 24'(2 * 524288 + Y_A * 65536 + int'(v));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic chk_frames(input string tag);
    chk({tag, " count"}, frames.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < frames.size(); i++)
      chk(tag, {8'h00, frames[i]}, {8'h00, exp_q[i]});
    frames.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " spi_start"}, bus.spi_start, 0);
    chk({tag, " spi_data"},  bus.spi_data, 0);
    chk({tag, " s_ready"},   bus.s_ready, 0);
    chk({tag, " init_done"}, init_done, 0);
    chk({tag, " running"},   running, 0);
    chk({tag, " underrun"},  underrun_cnt, 0);
    chk({tag, " overrun"},   overrun, 0);
  endtask

  initial begin
    int   ur_exp, acc_exp, n0;
    logic v;
    rst = 1; enable = 0; clear_status = 0;
    bus.s_valid = 0; bus.s_x = 0; bus.s_y = 0;
    busy_len = 400; hold_extra = 0;
    repeat (5) @(negedge clk);
    chk_reset("reset");

    // Init sequence
    rst = 0;
    for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
    chk("init timeout", init_done, 1);
    exp_q.push_back(24'h280001);
    exp_q.push_back(24'h380001);
    chk_frames("init frame");
    repeat (300) @(negedge clk);
    chk("idle no frames", frames.size(), 0);
    chk("idle running", running, 0);

    // Streaming with a fixed first pair, then randomized steps
    busy_len = 50;
    starts.delete(); accs.delete();
    ur_exp = 0; acc_exp = 1;
    bus.s_x = 16'h1234; bus.s_y = 16'hABCD; bus.s_valid = 1; enable = 1;
    for (int i = 0; i < 2 * TD && accs.size() == 0; i++) @(negedge clk);
    chk("first accept timeout", accs.size(), 1);
    exp_q.push_back(24'h001234);
    exp_q.push_back(24'h11ABCD);
    repeat (TD / 2) @(negedge clk);
    for (int step = 1; step <= 11; step++) begin
      if (step == 1) v = 1;
      else if (step <= 4) v = 0;
      else if (step <= 8) v = ($urandom_range(0, 3) != 0);
      else v = 1;
      if (step > 1) begin
        bus.s_x = 16'($urandom);
        bus.s_y = 16'($urandom);
      end
      bus.s_valid = v;
      if (step == 9) begin
        chk("overrun before late done", overrun, 0);
        hold_extra = TD + 20;
      end
      if (v && step != 10) begin
        exp_q.push_back(xf(bus.s_x));
        exp_q.push_back(yf(bus.s_y));
        acc_exp++;
      end
      if (!v) ur_exp++;
      repeat (TD) @(negedge clk);
    end
    bus.s_valid = 0;
    chk("accept count", accs.size(), acc_exp);
    if (accs.size() >= 2) chk("tick period", accs[1] - accs[0], TD);
    if (starts.size() >= 1 && accs.size() >= 1) chk("start latency", starts[0] - accs[0], 1);
    chk("underrun count", underrun_cnt, ur_exp);
    chk("overrun sticky", overrun, 1);
    chk_frames("stream frame");

    clear_status = 1;
    @(negedge clk);
    clear_status = 0;
    chk("clear underrun", underrun_cnt, 0);
    chk("clear overrun", overrun, 0);

    // Enable falls while the X frame is in flight
    bus.s_x = 16'($urandom); bus.s_y = 16'($urandom); bus.s_valid = 1;
    n0 = starts.size();
    for (int i = 0; i < 2 * TD && starts.size() == n0; i++) @(negedge clk);
    chk("drop x start timeout", starts.size(), n0 + 1);
    @(negedge clk);
    enable = 0; bus.s_valid = 0;
    exp_q.push_back(xf(bus.s_x));
    exp_q.push_back(yf(bus.s_y));
`ifdef MEMS_PARK_EN
    exp_q.push_back(24'h008000);
    exp_q.push_back(24'h118000);
`endif
    for (int i = 0; i < 4 * TD && running; i++) @(negedge clk);
    chk("drop running", running, 0);
    chk_frames("drop frame");
    repeat (2 * TD) @(negedge clk);
    chk("after drop frames", frames.size(), 0);
    chk("data stable", stab_err, 0);
    chk("single start", dbl_start, 0);

    // Reset in the middle of a Y frame
    enable = 1; bus.s_valid = 1;
    bus.s_x = 16'($urandom); bus.s_y = 16'($urandom);
    for (int i = 0; i < 3 * TD && frames.size() < 2; i++) @(negedge clk);
    chk("y start timeout", frames.size(), 2);
    repeat (10) @(negedge clk);
    rst = 1; enable = 0; bus.s_valid = 0;
    @(negedge clk);
    chk_reset("mid rst");
    frames.delete();
    busy_len = 400;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
    chk("reinit timeout", init_done, 1);
    exp_q.push_back(24'h280001);
    exp_q.push_back(24'h380001);
    chk_frames("reinit frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
